// File: rtl/xadac_axi_wr_arb.sv
// xadac_axi_wr_arb
// Lets NumReq xadac store-type units share one single-beat AXI write port.
//   AW : round-robin arbitration into a registered output slot. Each grant
//        pushes the winner index into a small order FIFO.
//   W  : only the requester at the FIFO head may send a beat. W therefore
//        follows AW grant order and never gets ahead of its own AW.
//   B  : combinational routing back to the requester whose index sits in
//        the upper master ID bits. An out-of-range index is sunk, and the
//        sticky err_b_sel flag is set.
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   s_aw_* / s_w_* / s_b_* per-requester slave channels (packed, requester i
//                          occupies field i)
//   m_aw_* / m_w_* / m_b_* shared master channels, m_aw_id = {sel, id}
//   err_b_sel              sticky: B seen with sel >= NumReq
module xadac_axi_wr_arb #(
  parameter int unsigned NumReq     = 2,
  parameter int unsigned IdWidth    = 4,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 256,
  parameter int unsigned OrderDepth = 4,
  parameter int unsigned SelWidth   = $clog2(NumReq)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NumReq*IdWidth-1:0]         s_aw_id,
  input  logic [NumReq*AddrWidth-1:0]       s_aw_addr,
  input  logic [NumReq-1:0]                 s_aw_valid,
  output logic [NumReq-1:0]                 s_aw_ready,
  input  logic [NumReq*DataWidth-1:0]       s_w_data,
  input  logic [NumReq*DataWidth/8-1:0]     s_w_strb,
  input  logic [NumReq-1:0]                 s_w_valid,
  output logic [NumReq-1:0]                 s_w_ready,
  output logic [NumReq*IdWidth-1:0]         s_b_id,
  output logic [NumReq-1:0]                 s_b_valid,
  input  logic [NumReq-1:0]                 s_b_ready,
  output logic [IdWidth+SelWidth-1:0]       m_aw_id,
  output logic [AddrWidth-1:0]              m_aw_addr,
  output logic                              m_aw_valid,
  input  logic                              m_aw_ready,
  output logic [DataWidth-1:0]              m_w_data,
  output logic [DataWidth/8-1:0]            m_w_strb,
  output logic                              m_w_valid,
  input  logic                              m_w_ready,
  input  logic [IdWidth+SelWidth-1:0]       m_b_id,
  input  logic                              m_b_valid,
  output logic                              m_b_ready,
  output logic                              err_b_sel
);

  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned PtrW  = $clog2(OrderDepth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned MIdW  = IdWidth + SelWidth;

  // registers
  logic [SelWidth-1:0]  r_ptr;
  logic [SelWidth-1:0]  r_fifo [OrderDepth];
  logic [PtrW-1:0]      r_rd;
  logic [PtrW-1:0]      r_wr;
  logic [CntW-1:0]      r_cnt;
  logic [MIdW-1:0]      r_aw_id;
  logic [AddrWidth-1:0] r_aw_addr;
  logic                 r_aw_valid;
  logic [DataWidth-1:0] r_w_data;
  logic [StrbW-1:0]     r_w_strb;
  logic                 r_w_valid;
  logic                 r_err;

  // wires
  logic                 w_aw_any;
  logic [SelWidth-1:0]  w_win;
  logic [IdWidth-1:0]   w_win_id;
  logic [AddrWidth-1:0] w_win_addr;
  logic                 w_aw_free;
  logic                 w_full;
  logic                 w_grant;
  logic [SelWidth-1:0]  w_head;
  logic                 w_w_free;
  logic                 w_w_ok;
  logic                 w_w_hs;
  logic [DataWidth-1:0] w_head_data;
  logic [StrbW-1:0]     w_head_strb;
  logic [SelWidth-1:0]  w_b_sel;
  logic                 w_b_sel_ok;

  assign m_aw_id    = r_aw_id;
  assign m_aw_addr  = r_aw_addr;
  assign m_aw_valid = r_aw_valid;
  assign m_w_data   = r_w_data;
  assign m_w_strb   = r_w_strb;
  assign m_w_valid  = r_w_valid;
  assign err_b_sel  = r_err;

  // ---------------------------------------------------------------- AW
  // Scan from r_ptr upward. Each candidate index wraps at NumReq, which
  // need not be a power of two.
  always_comb begin
    logic [SelWidth:0] v_idx;
    w_aw_any   = 1'b0;
    w_win      = '0;
    w_win_id   = '0;
    w_win_addr = '0;
    v_idx      = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      v_idx = {1'b0, r_ptr} + (SelWidth+1)'(k);
      if (v_idx >= (SelWidth+1)'(NumReq)) v_idx = v_idx - (SelWidth+1)'(NumReq);
      if (!w_aw_any && s_aw_valid[v_idx[SelWidth-1:0]]) begin
        w_aw_any = 1'b1;
        w_win    = v_idx[SelWidth-1:0];
      end
    end
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (SelWidth'(i) == w_win) begin
        w_win_id   = s_aw_id[i*IdWidth +: IdWidth];
        w_win_addr = s_aw_addr[i*AddrWidth +: AddrWidth];
      end
    end
  end

  assign w_aw_free = !r_aw_valid || m_aw_ready;
  // Only the registered count is used here. A pop in this same cycle does
  // not open room for a grant.
  assign w_full    = (r_cnt == CntW'(OrderDepth));
  assign w_grant   = w_aw_free && !w_full && w_aw_any;

  always_comb begin
    s_aw_ready = '0;
    if (w_grant) s_aw_ready[w_win] = 1'b1;
  end

  // ----------------------------------------------------------------- W
  assign w_head   = r_fifo[r_rd];
  assign w_w_free = !r_w_valid || m_w_ready;
  assign w_w_ok   = w_w_free && (r_cnt != '0);
  assign w_w_hs   = w_w_ok && s_w_valid[w_head];

  always_comb begin
    s_w_ready   = '0;
    w_head_data = '0;
    w_head_strb = '0;
    if (w_w_ok) s_w_ready[w_head] = 1'b1;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (SelWidth'(i) == w_head) begin
        w_head_data = s_w_data[i*DataWidth +: DataWidth];
        w_head_strb = s_w_strb[i*StrbW +: StrbW];
      end
    end
  end

  // ----------------------------------------------------------------- B
  assign w_b_sel    = m_b_id[IdWidth +: SelWidth];
  assign w_b_sel_ok = ((SelWidth+1)'(w_b_sel) < (SelWidth+1)'(NumReq));

  always_comb begin
    s_b_valid = '0;
    s_b_id    = '0;
    m_b_ready = 1'b1;
    if (w_b_sel_ok) begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (SelWidth'(i) == w_b_sel) begin
          s_b_valid[i]                  = m_b_valid;
          s_b_id[i*IdWidth +: IdWidth]  = m_b_id[IdWidth-1:0];
          m_b_ready                     = s_b_ready[i];
        end
      end
    end
  end

  // ------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr      <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_cnt      <= '0;
      r_aw_id    <= '0;
      r_aw_addr  <= '0;
      r_aw_valid <= 1'b0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_w_valid  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_grant) begin
        r_aw_valid <= 1'b1;
        r_aw_id    <= {w_win, w_win_id};
        r_aw_addr  <= w_win_addr;
        r_ptr      <= (w_win == SelWidth'(NumReq-1)) ? '0 : w_win + 1'b1;
        r_wr       <= r_wr + 1'b1;
      end else if (m_aw_ready) begin
        r_aw_valid <= 1'b0;
      end

      if (w_w_hs) begin
        r_w_valid <= 1'b1;
        r_w_data  <= w_head_data;
        r_w_strb  <= w_head_strb;
        r_rd      <= r_rd + 1'b1;
      end else if (m_w_ready) begin
        r_w_valid <= 1'b0;
      end

      case ({w_grant, w_w_hs})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase

      if (m_b_valid && !w_b_sel_ok) r_err <= 1'b1;
    end
  end

  // FIFO storage carries no reset; entries are only read below r_cnt.
  always_ff @(posedge clk) begin
    if (w_grant) r_fifo[r_wr] <= w_win;
  end

endmodule

// File: tb/tb_xadac_axi_wr_arb.sv
module tb_xadac_axi_wr_arb;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- instance A: NumReq=2, OrderDepth=4, DataWidth=32
  logic [7:0]  a_aw_id;
  logic [63:0] a_aw_addr;
  logic [1:0]  a_aw_valid, a_aw_ready;
  logic [63:0] a_w_data;
  logic [7:0]  a_w_strb;
  logic [1:0]  a_w_valid, a_w_ready;
  logic [7:0]  a_b_id;
  logic [1:0]  a_b_valid, a_b_ready;
  logic [4:0]  a_m_aw_id;
  logic [31:0] a_m_aw_addr;
  logic        a_m_aw_valid, a_m_aw_ready;
  logic [31:0] a_m_w_data;
  logic [3:0]  a_m_w_strb;
  logic        a_m_w_valid, a_m_w_ready;
  logic [4:0]  a_m_b_id;
  logic        a_m_b_valid, a_m_b_ready;
  logic        a_err;

  xadac_axi_wr_arb #(
    .NumReq(2), .IdWidth(4), .AddrWidth(32), .DataWidth(32), .OrderDepth(4)
  ) u_dut_a (
    .clk(clk), .rstn(rstn),
    .s_aw_id(a_aw_id), .s_aw_addr(a_aw_addr), .s_aw_valid(a_aw_valid), .s_aw_ready(a_aw_ready),
    .s_w_data(a_w_data), .s_w_strb(a_w_strb), .s_w_valid(a_w_valid), .s_w_ready(a_w_ready),
    .s_b_id(a_b_id), .s_b_valid(a_b_valid), .s_b_ready(a_b_ready),
    .m_aw_id(a_m_aw_id), .m_aw_addr(a_m_aw_addr), .m_aw_valid(a_m_aw_valid), .m_aw_ready(a_m_aw_ready),
    .m_w_data(a_m_w_data), .m_w_strb(a_m_w_strb), .m_w_valid(a_m_w_valid), .m_w_ready(a_m_w_ready),
    .m_b_id(a_m_b_id), .m_b_valid(a_m_b_valid), .m_b_ready(a_m_b_ready),
    .err_b_sel(a_err)
  );

  // ---------------- instance B: NumReq=3 (sel=3 is out of range)
  logic [11:0] b_aw_id;
  logic [95:0] b_aw_addr;
  logic [2:0]  b_aw_valid, b_aw_ready;
  logic [95:0] b_w_data;
  logic [11:0] b_w_strb;
  logic [2:0]  b_w_valid, b_w_ready;
  logic [11:0] b_b_id;
  logic [2:0]  b_b_valid, b_b_ready;
  logic [5:0]  b_m_aw_id;
  logic [31:0] b_m_aw_addr;
  logic        b_m_aw_valid, b_m_aw_ready;
  logic [31:0] b_m_w_data;
  logic [3:0]  b_m_w_strb;
  logic        b_m_w_valid, b_m_w_ready;
  logic [5:0]  b_m_b_id;
  logic        b_m_b_valid, b_m_b_ready;
  logic        b_err;

  xadac_axi_wr_arb #(
    .NumReq(3), .IdWidth(4), .AddrWidth(32), .DataWidth(32), .OrderDepth(4)
  ) u_dut_b (
    .clk(clk), .rstn(rstn),
    .s_aw_id(b_aw_id), .s_aw_addr(b_aw_addr), .s_aw_valid(b_aw_valid), .s_aw_ready(b_aw_ready),
    .s_w_data(b_w_data), .s_w_strb(b_w_strb), .s_w_valid(b_w_valid), .s_w_ready(b_w_ready),
    .s_b_id(b_b_id), .s_b_valid(b_b_valid), .s_b_ready(b_b_ready),
    .m_aw_id(b_m_aw_id), .m_aw_addr(b_m_aw_addr), .m_aw_valid(b_m_aw_valid), .m_aw_ready(b_m_aw_ready),
    .m_w_data(b_m_w_data), .m_w_strb(b_m_w_strb), .m_w_valid(b_m_w_valid), .m_w_ready(b_m_w_ready),
    .m_b_id(b_m_b_id), .m_b_valid(b_m_b_valid), .m_b_ready(b_m_b_ready),
    .err_b_sel(b_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    a_aw_id = '0; a_aw_addr = '0; a_aw_valid = '0;
    a_w_data = '0; a_w_strb = '0; a_w_valid = '0; a_b_ready = '0;
    a_m_aw_ready = 1'b0; a_m_w_ready = 1'b0; a_m_b_id = '0; a_m_b_valid = 1'b0;
    b_aw_id = '0; b_aw_addr = '0; b_aw_valid = '0;
    b_w_data = '0; b_w_strb = '0; b_w_valid = '0; b_b_ready = '0;
    b_m_aw_ready = 1'b0; b_m_w_ready = 1'b0; b_m_b_id = '0; b_m_b_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  initial begin
    do_reset();
    #1;
    // idle after reset
    check_eq("rst_aw_ready", 64'(a_aw_ready), 64'h0);
    check_eq("rst_w_ready", 64'(a_w_ready), 64'h0);
    check_eq("rst_m_aw_valid", 64'(a_m_aw_valid), 64'h0);
    check_eq("rst_m_aw_addr", 64'(a_m_aw_addr), 64'h0);
    check_eq("rst_m_w_valid", 64'(a_m_w_valid), 64'h0);
    check_eq("rst_err_a", 64'(a_err), 64'h0);
    check_eq("rst_err_b", 64'(b_err), 64'h0);
    check_eq("rst_b_valid", 64'(a_b_valid), 64'h0);

    // round robin: both requesters every cycle, four grants fill the FIFO
    a_aw_id    = {4'hB, 4'hA};
    a_aw_addr  = {32'h0000_2000, 32'h0000_1000};
    a_aw_valid = 2'b11;
    a_m_aw_ready = 1'b1;
    #1;
    check_eq("rr_first_ready", 64'(a_aw_ready), 64'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("rr_m_aw_valid", 64'(a_m_aw_valid), 64'h1);
      check_eq("rr_m_aw_id", 64'(a_m_aw_id), (i % 2 == 0) ? 64'h0A : 64'h1B);
      check_eq("rr_aw_ready", 64'(a_aw_ready),
               (i == 3) ? 64'h0 : ((i % 2 == 0) ? 64'h2 : 64'h1));
    end

    // slot held while m_aw_ready=0; FIFO full keeps grants off
    a_m_aw_ready = 1'b0;
    a_m_w_ready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_aw_addr = {32'hBEEF_0000 + 32'(i), 32'hDEAD_0000 + 32'(i)};
      tick();
      check_eq("hold_m_aw_addr", 64'(a_m_aw_addr), 64'h2000);
      check_eq("hold_aw_ready", 64'(a_aw_ready), 64'h0);
    end
    check_eq("hold_m_aw_id", 64'(a_m_aw_id), 64'h1B);

    // full FIFO blocks grant even with a same-cycle pop
    a_w_data  = {32'hD1A0_0001, 32'hD0A0_0000};
    a_w_strb  = {4'hF, 4'h3};
    a_w_valid = 2'b11;
    a_m_aw_ready = 1'b1;
    #1;
    check_eq("full_w_ready", 64'(a_w_ready), 64'h1);
    check_eq("full_pop_aw_ready", 64'(a_aw_ready), 64'h0);
    tick();
    check_eq("pop_m_w_valid", 64'(a_m_w_valid), 64'h1);
    check_eq("pop_m_w_data", 64'(a_m_w_data), 64'hD0A0_0000);
    check_eq("pop_m_w_strb", 64'(a_m_w_strb), 64'h3);
    check_eq("pop_m_aw_valid", 64'(a_m_aw_valid), 64'h0);
    check_eq("after_pop_aw_ready", 64'(a_aw_ready), 64'h1);
    check_eq("w_slot_busy_w_ready", 64'(a_w_ready), 64'h0);

    // reset mid-transaction drops everything
    do_reset();
    #1;
    check_eq("mid_rst_m_w_valid", 64'(a_m_w_valid), 64'h0);
    check_eq("mid_rst_m_aw_valid", 64'(a_m_aw_valid), 64'h0);
    check_eq("mid_rst_m_w_data", 64'(a_m_w_data), 64'h0);

    // W before its AW is never accepted
    a_w_data  = {32'h1111_BBBB, 32'h0000_AAAA};
    a_w_strb  = {4'hC, 4'h5};
    a_w_valid = 2'b10;
    a_m_aw_ready = 1'b1;
    a_m_w_ready  = 1'b1;
    #1;
    check_eq("early_w_ready", 64'(a_w_ready), 64'h0);
    tick();
    check_eq("early_w_ready2", 64'(a_w_ready), 64'h0);
    a_w_valid = 2'b00;

    // AW order req1 then req0
    a_aw_id    = {4'h7, 4'h2};
    a_aw_addr  = {32'h0000_7000, 32'h0000_3000};
    a_aw_valid = 2'b10;
    #1;
    check_eq("ord_aw_ready1", 64'(a_aw_ready), 64'h2);
    tick();
    check_eq("ord_m_aw_id1", 64'(a_m_aw_id), 64'h17);
    a_aw_valid = 2'b01;
    #1;
    check_eq("ord_aw_ready0", 64'(a_aw_ready), 64'h1);
    tick();
    check_eq("ord_m_aw_id0", 64'(a_m_aw_id), 64'h02);
    a_aw_valid = 2'b00;

    a_w_valid = 2'b11;
    #1;
    check_eq("ord_w_ready_head1", 64'(a_w_ready), 64'h2);
    tick();
    check_eq("ord_m_w_data1", 64'(a_m_w_data), 64'h1111_BBBB);
    check_eq("ord_m_w_strb1", 64'(a_m_w_strb), 64'hC);
    check_eq("ord_w_ready_head0", 64'(a_w_ready), 64'h1);
    tick();
    check_eq("ord_m_w_data0", 64'(a_m_w_data), 64'h0000_AAAA);
    check_eq("ord_m_w_valid0", 64'(a_m_w_valid), 64'h1);
    a_w_valid = 2'b00;
    #1;
    check_eq("empty_w_ready", 64'(a_w_ready), 64'h0);
    tick();
    check_eq("drain_m_w_valid", 64'(a_m_w_valid), 64'h0);

    // B routing to requester 1 under backpressure
    a_m_b_id    = {1'b1, 4'h3};
    a_m_b_valid = 1'b1;
    a_b_ready   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("b1_valid", 64'(a_b_valid), 64'h2);
      check_eq("b1_id", 64'(a_b_id), 64'h30);
      check_eq("b1_m_ready_lo", 64'(a_m_b_ready), 64'h0);
      tick();
    end
    a_b_ready = 2'b01;
    #1;
    check_eq("b1_other_ready", 64'(a_m_b_ready), 64'h0);
    a_b_ready = 2'b10;
    #1;
    check_eq("b1_valid_hi", 64'(a_b_valid), 64'h2);
    check_eq("b1_m_ready_hi", 64'(a_m_b_ready), 64'h1);
    a_m_b_id  = {1'b0, 4'h5};
    a_b_ready = 2'b01;
    #1;
    check_eq("b0_valid", 64'(a_b_valid), 64'h1);
    check_eq("b0_id", 64'(a_b_id), 64'h05);
    check_eq("b0_m_ready", 64'(a_m_b_ready), 64'h1);
    a_m_b_valid = 1'b0;
    #1;
    check_eq("b_novalid", 64'(a_b_valid), 64'h0);
    tick();
    check_eq("a_err_clean", 64'(a_err), 64'h0);

    // NumReq=3: sel=3 is sunk and flagged
    b_m_b_id    = {2'd3, 4'h5};
    b_m_b_valid = 1'b1;
    b_b_ready   = 3'b000;
    #1;
    check_eq("bad_m_b_ready", 64'(b_m_b_ready), 64'h1);
    check_eq("bad_s_b_valid", 64'(b_b_valid), 64'h0);
    check_eq("bad_err_before", 64'(b_err), 64'h0);
    tick();
    check_eq("bad_err_set", 64'(b_err), 64'h1);
    b_m_b_id = {2'd2, 4'h5};
    #1;
    check_eq("b2_valid", 64'(b_b_valid), 64'h4);
    check_eq("b2_id", 64'(b_b_id), 64'h500);
    b_m_b_valid = 1'b0;
    tick();
    check_eq("bad_err_sticky", 64'(b_err), 64'h1);
    rstn = 1'b0;
    #1;
    check_eq("bad_err_async_clr", 64'(b_err), 64'h0);
    #5 rstn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
